parallel_out_uart_tx: RTL
=========================

Name: parallel_out_uart_tx

Overview:
- Downstream consumer of the memory-mapped output port (address 0xFF).
- Takes the port's byte and one-cycle write strobe, queues each written byte in a small FIFO, and serializes it as 8N1 UART on a single TX pin, LSB first.
- Lets CPU software stream characters off-chip without polling, as long as the FIFO is not full.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 4, number of queued bytes; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- wren  input  1  write strobe from the output port; one byte per high cycle.
- dataIn  input  8  byte from the output port, sampled when wren=1.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset (rst=1 at a rising edge):
  - tx=1, busy=0, full=0, overflow=0.
  - FIFO emptied (read and write pointers 0, count 0), FSM to IDLE, baud counter and bit index to 0.
  - Reset mid-frame aborts the frame immediately; tx returns high at that edge.
- FIFO write:
  - At an edge with wren=1, dataIn is stored if count < FIFO_DEPTH, or if count == FIFO_DEPTH and the FSM pops at the same edge.
  - Otherwise the byte is dropped and overflow is set to 1, held until reset.
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves count unchanged.
- full and busy are registered outputs derived from post-edge state:
  - full = (count == FIFO_DEPTH).
  - busy = (state != IDLE) | (count != 0).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count != 0, pop the head byte into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - The state or bit advances at the edge where the counter equals CLKS_PER_BIT-1; the counter then resets to 0.
- tx is registered.
  - Write into an empty FIFO at edge N with FSM in IDLE: pop at edge N+1, tx low from edge N+1.
  - Frame length is 10*CLKS_PER_BIT cycles.
- Back-to-back frames: STOP exits to IDLE, and IDLE pops on the next edge. Inter-frame gap is exactly 1 cycle of tx=1 beyond the stop bit.
- wren while FSM is busy only affects the FIFO; the frame in flight is never altered.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11*CLKS_PER_BIT cycles.
- Undefined: no parity state; 8N1 as above.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. Reset: hold rst 2 cycles -> tx=1, busy=0, full=0, overflow=0; stay so with no writes for 50 cycles.
2. Single byte: wren=1, dataIn=0x55 for one cycle at edge N -> tx=0 over edges N+1..N+4, then bits 1,0,1,0,1,0,1,0 (4 cycles each), stop=1 for 4 cycles. busy falls at the end of stop.
3. Burst/full: five consecutive wren cycles (0x01..0x05) starting from IDLE -> 0x01 pops at edge 2, so 0x05 is accepted and full=1. A sixth write 0x06 -> dropped, overflow=1. Line emits 0x01..0x05 in order, each gap exactly 1 idle cycle.
4. Push/pop same edge: FIFO full with FSM in STOP final cycle, wren=1, dataIn=0xA3 at the pop edge -> accepted, overflow stays 0, full stays 1.
5. Reset mid-frame: write 0xFF, assert rst during DATA bit 3 -> tx=1 at that edge, FIFO empty, busy=0. A new write of 0x0F afterwards transmits a clean frame.
6. Parity (UART_TX_PARITY_EN defined): send 0x07 -> parity bit 1. Send 0x03 -> parity bit 0. Frame length 44 cycles.

Source files
------------

// File: rtl/parallel_out_uart_tx.sv
// UART transmitter fed by the memory-mapped output port (address 0xFF).
// Bytes written with wren are queued in a small FIFO and sent as 8N1, LSB first.
// Ports:
//   clk      rising-edge system clock
//   rst      synchronous active-high reset
//   wren     one-cycle write strobe, one byte per high cycle
//   dataIn   byte sampled when wren=1
//   tx       registered UART line, idles high
//   busy     frame on the line or FIFO non-empty
//   full     FIFO holds FIFO_DEPTH bytes
//   overflow sticky: a write was dropped
// Optional macro UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module parallel_out_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wren,
    input  logic [7:0] dataIn,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_d;
    logic            pop;
    logic            push;
    logic            baud_last;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    // Pop only from IDLE; a push into a full FIFO is legal on the pop edge.
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign push      = wren && ((count_q != CW'(FIFO_DEPTH)) || pop);
    assign count_d   = count_q + CW'(push) - CW'(pop);
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    // FIFO storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= dataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            if (wren && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = ^mem[rd_ptr_q];
`endif
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // tx is decoded from the post-edge state so the line changes on the
    // same edge the FSM moves.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
            tx      <= 1'b1;
            busy    <= 1'b0;
            full    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
            tx      <= tx_d;
            busy    <= (state_d != IDLE) || (count_d != '0);
            full    <= (count_d == CW'(FIFO_DEPTH));
        end
    end

endmodule
